// File: rtl/alu_muldiv.sv
// Registered ALU with valid/ready handshake and an optional iterative multiply/divide unit.
// Define ALU_MULDIV_MEXT_EN to build the M-extension datapath; otherwise every 1xxxx op returns 0.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic             accept;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] base_res;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign zero      = (alu_out == '0);
  assign shamt     = b[SW-1:0];

  always_comb begin
    base_res = '0;
    if (!alu_ctrl[4]) begin
      case (alu_ctrl[3:0])
        4'b0000: base_res = a + b;
        4'b0001: base_res = a - b;
        4'b0010: base_res = a & b;
        4'b0011: base_res = a | b;
        4'b0100: base_res = a << shamt;
        4'b0101: base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        4'b0110: base_res = $signed(a) >>> shamt;
        4'b0111: base_res = a >> shamt;
        4'b1000: base_res = {{(WIDTH-1){1'b0}}, a < b};
        4'b1001: base_res = a ^ b;
        4'b1111: base_res = b;
        default: base_res = '0;
      endcase
    end
  end

`ifdef ALU_MULDIV_MEXT_EN
  localparam int CW = $clog2(WIDTH + 1);

  // acc holds {product hi, multiplier/product lo} for MUL and {remainder, quotient} for DIV
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH-1:0]   opnd, a_mag, b_mag, div_mag, fin_res, launch_res;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic [1:0]         mop;
  logic               neg, neg_init, a_neg, b_neg;
  state_t             launch_state;

  always_comb begin
    a_neg = a[WIDTH-1] && (alu_ctrl[2:0] == 3'b001 || alu_ctrl[2:0] == 3'b010 ||
                           alu_ctrl[2:0] == 3'b100 || alu_ctrl[2:0] == 3'b110);
    b_neg = b[WIDTH-1] && (alu_ctrl[2:0] == 3'b001 || alu_ctrl[2:0] == 3'b100 ||
                           alu_ctrl[2:0] == 3'b110);
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    // remainder takes the dividend's sign, everything else the product/quotient sign
    neg_init = a_neg ^ (b_neg && !(alu_ctrl[2] && alu_ctrl[1]));
    launch_state = DONE;
    launch_res   = base_res;
    if (alu_ctrl[4:3] == 2'b10) begin
      if (!alu_ctrl[2])
        launch_state = MUL;
      else if (b == '0)
        launch_res = alu_ctrl[1] ? a : '1;
      else if (!alu_ctrl[0] && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1)
        launch_res = alu_ctrl[1] ? '0 : a;
      else
        launch_state = DIV;
    end
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (state == MUL)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_step = {acc[2*WIDTH-2:0], 1'b0};
    else
      acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_fix = neg ? -acc_step : acc_step;
    div_mag  = mop[1] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
    if (state == MUL)
      fin_res = (mop == 2'b00) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    else
      fin_res = neg ? -div_mag : div_mag;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      alu_out <= '0;
`ifdef ALU_MULDIV_MEXT_EN
      count <= '0;
      acc   <= '0;
      opnd  <= '0;
      mop   <= '0;
      neg   <= 1'b0;
`endif
    end else if (accept) begin
`ifdef ALU_MULDIV_MEXT_EN
      state <= launch_state;
      if (launch_state == DONE)
        alu_out <= launch_res;
      count <= '0;
      acc   <= {{WIDTH{1'b0}}, alu_ctrl[2] ? a_mag : b_mag};
      opnd  <= alu_ctrl[2] ? b_mag : a_mag;
      mop   <= alu_ctrl[1:0];
      neg   <= neg_init;
`else
      state   <= DONE;
      alu_out <= base_res;
`endif
    end else if (state == DONE) begin
      if (out_ready)
        state <= IDLE;
    end
`ifdef ALU_MULDIV_MEXT_EN
    else if (state == MUL || state == DIV) begin
      acc   <= acc_step;
      count <= count + CW'(1);
      if (count == CW'(WIDTH - 1)) begin
        state   <= DONE;
        alu_out <= fin_res;
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): behavioural model plus directed literal cases.
// Follows ALU_MULDIV_MEXT_EN to choose which M-op results and latencies to expect.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [4:0]  alu_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic        zero;

  int compared   = 0;
  int mismatched = 0;
  int edges      = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc_edge;
  } exp_t;

  exp_t q[$];
  bit   front_seen = 1'b0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] ref_result(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
    int          sx = x;
    int          sy = y;
    logic [63:0] p;
    logic        ovf = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
    case (c)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x & y;
      5'd3:  return x | y;
      5'd4:  return x << y[4:0];
      5'd5:  return (sx < sy) ? 32'd1 : 32'd0;
      5'd6:  return sx >>> y[4:0];
      5'd7:  return x >> y[4:0];
      5'd8:  return (x < y) ? 32'd1 : 32'd0;
      5'd9:  return x ^ y;
      5'd15: return y;
`ifdef ALU_MULDIV_MEXT_EN
      5'd16: return x * y;
      5'd17: begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; return p[63:32]; end
      5'd18: begin p = {{32{x[31]}}, x} * {32'd0, y}; return p[63:32]; end
      5'd19: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      5'd20: return (y == 0) ? 32'hFFFFFFFF : ovf ? x : sx / sy;
      5'd21: return (y == 0) ? 32'hFFFFFFFF : x / y;
      5'd22: return (y == 0) ? x : ovf ? 32'd0 : sx % sy;
      5'd23: return (y == 0) ? x : x % y;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
`ifdef ALU_MULDIV_MEXT_EN
    if (c >= 5'd16 && c <= 5'd19) return 33;
    if (c >= 5'd20 && c <= 5'd23) begin
      if (y == 0) return 1;
      if ((c == 5'd20 || c == 5'd22) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
      return 33;
    end
`endif
    return 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
    end
  endtask

  // Sampled 1ns before each rising edge: inputs and outputs are settled for that cycle.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        q.delete();
        front_seen = 1'b0;
      end else begin
        if (q.size() == 0) begin
          checkOutput("idle_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          int elapsed = edges - q[0].acc_edge + 1;
          if (out_valid) begin
            if (!front_seen) begin
              front_seen = 1'b1;
              checkOutput("model_latency", elapsed, q[0].lat);
            end
            checkOutput("model_result", alu_out, q[0].res);
            checkOutput("model_zero", {31'd0, zero}, {31'd0, q[0].res == 32'd0});
            if (out_ready) begin
              void'(q.pop_front());
              front_seen = 1'b0;
            end
          end else if (elapsed >= q[0].lat) begin
            checkOutput("model_late_valid", {31'd0, out_valid}, 32'd1);
            void'(q.pop_front());
            front_seen = 1'b0;
          end
        end
        if (in_valid && in_ready)
          q.push_back('{ref_result(alu_ctrl, a, b), ref_latency(alu_ctrl, a, b), edges + 1});
      end
    end
  end

  task automatic issue(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y);
    int tries = 0;
    in_valid = 1'b1;
    alu_ctrl = c;
    a = x;
    b = y;
    #1;
    while (!in_ready && tries < 200) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", tries);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    alu_ctrl = 5'($urandom);
  endtask

  task automatic waitResult(input int hold, input logic [31:0] expv, output logic [31:0] res, output int lat);
    int n = 1;
    #1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    lat = n;
    res = alu_out;
    if (!out_valid) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL result_timeout: out_valid=0 after %0d cycles, required 1", n);
    end else if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        #1;
        checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("hold_alu_out", alu_out, expv);
      end
      out_ready = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [4:0] c, input logic [31:0] x, input logic [31:0] y,
                               input int hold, output logic [31:0] res, output int lat);
    issue(c, x, y);
    waitResult(hold, ref_result(c, x, y), res, lat);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r;
    int          l;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    alu_ctrl  = '0;
    #1;
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_alu_out", alu_out, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_zero", {31'd0, zero}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(5'b00000, 32'd5, 32'd7, 0, r, l);
    checkOutput("add_result", r, 32'd12);
    checkOutput("add_latency", l, 32'd1);
    checkOutput("add_zero", {31'd0, zero}, 32'd0);
    applyStimulus(5'b00001, 32'd7, 32'd7, 0, r, l);
    checkOutput("sub_result", r, 32'd0);
    checkOutput("sub_zero", {31'd0, zero}, 32'd1);

    applyStimulus(5'b00110, 32'h80000000, 32'd4, 0, r, l);
    checkOutput("sra_result", r, 32'hF8000000);
    applyStimulus(5'b00100, 32'd1, 32'h0000003F, 0, r, l);
    checkOutput("sll_result", r, 32'h80000000);
    applyStimulus(5'b00101, 32'hFFFFFFFF, 32'd1, 0, r, l);
    checkOutput("slt_result", r, 32'd1);
    applyStimulus(5'b01000, 32'hFFFFFFFF, 32'd1, 0, r, l);
    checkOutput("sltu_result", r, 32'd0);
    applyStimulus(5'b01111, 32'd3, 32'hA5A5A5A5, 0, r, l);
    checkOutput("passb_result", r, 32'hA5A5A5A5);
    applyStimulus(5'b01010, 32'd3, 32'd4, 0, r, l);
    checkOutput("undef_result", r, 32'd0);

`ifdef ALU_MULDIV_MEXT_EN
    applyStimulus(5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, r, l);
    checkOutput("mulhu_result", r, 32'hFFFFFFFE);
    checkOutput("mulhu_latency", l, 32'd33);
    applyStimulus(5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, r, l);
    checkOutput("mul_result", r, 32'h00000001);
    applyStimulus(5'b10001, 32'h80000000, 32'h80000000, 0, r, l);
    checkOutput("mulh_result", r, 32'h40000000);
    applyStimulus(5'b10100, 32'd7, 32'hFFFFFFFE, 0, r, l);
    checkOutput("div_result", r, 32'hFFFFFFFD);
    checkOutput("div_latency", l, 32'd33);
    applyStimulus(5'b10110, 32'd7, 32'hFFFFFFFE, 0, r, l);
    checkOutput("rem_result", r, 32'h00000001);
    applyStimulus(5'b10101, 32'd9, 32'd0, 0, r, l);
    checkOutput("divu_by0_result", r, 32'hFFFFFFFF);
    checkOutput("divu_by0_latency", l, 32'd1);
    applyStimulus(5'b10110, 32'h80000000, 32'hFFFFFFFF, 0, r, l);
    checkOutput("rem_ovf_result", r, 32'd0);
    checkOutput("rem_ovf_latency", l, 32'd1);
`else
    applyStimulus(5'b10000, 32'd3, 32'd4, 0, r, l);
    checkOutput("nomext_mul_result", r, 32'd0);
    checkOutput("nomext_mul_zero", {31'd0, zero}, 32'd1);
    checkOutput("nomext_mul_latency", l, 32'd1);
    applyStimulus(5'b10101, 32'd9, 32'd0, 0, r, l);
    checkOutput("nomext_divu_result", r, 32'd0);
`endif

    // Back-pressure, then an accept in the same cycle the held result drains.
    applyStimulus(5'b00000, 32'd100, 32'd23, 5, r, l);
    checkOutput("bp_result", r, 32'd123);
    in_valid = 1'b1;
    alu_ctrl = 5'b00000;
    a        = 32'd1;
    b        = 32'd2;
    #1;
    checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(5'b00000, 32'd1, 32'd2, 0, r, l);
    checkOutput("b2b_result", r, 32'd3);
    checkOutput("b2b_latency", l, 32'd1);

    // Reset in the middle of a divide.
    issue(5'b10100, 32'd1000, 32'd7);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_alu_out", alu_out, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("midrst_zero", {31'd0, zero}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (i % 10 == 9)
        checkOutput("postrst_out_valid", {31'd0, out_valid}, 32'd0);
    end

    for (int i = 0; i < 300; i++) begin
      int hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(5'($urandom_range(0, 31)), pick_operand(), pick_operand(), hold, r, l);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >=8).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have ports a, b  input  WIDTH  operands (a = rs1, b = rs2/imm).
REQ-007 SHALL have port alu_ctrl  input  5  operation select.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port alu_out  output  WIDTH  registered result.
REQ-011 SHALL have port zero  output  1  high when alu_out == 0.

Function
REQ-012 SHALL accept a request on a rising edge where in_valid && in_ready, capturing a, b and alu_ctrl; later input changes have no effect on that request.
REQ-013 SHALL decode base ops: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SLT (signed), 00110 SRA, 00111 SRL, 01000 SLTU, 01001 XOR, 01111 pass b; shift amount b[$clog2(WIDTH)-1:0]; any other 0xxxx yields 0.
REQ-014 SHALL decode M-ops: 10000 MUL (low half), 10001 MULH (s x s), 10010 MULHSU (s x u), 10011 MULHU (u x u), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU; 11xxx yields 0 as a base-latency op.
REQ-015 SHALL use FSM states IDLE, MUL, DIV, DONE; IDLE->DONE on accepted base/special op, IDLE->MUL or DIV on accepted M-op, MUL/DIV->DONE when iteration counter reaches WIDTH, DONE->IDLE on out_ready with no new accept, DONE->DONE/MUL/DIV on out_ready with a simultaneous accept.
REQ-016 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready), combinationally.
REQ-017 SHALL assert out_valid only in DONE; base ops reach DONE on the 1st rising edge after accept, MUL*/DIV*/REM* on the (WIDTH+1)th.
REQ-018 SHALL compute multiply iteratively, one shift-add per cycle over a 2*WIDTH product with sign correction per REQ-014; division iteratively, one restoring step per cycle on magnitudes, signs applied at completion (quotient sign a^b, remainder sign of a).
REQ-019 SHALL treat divide-by-zero as special (1-cycle): DIV/DIVU quotient all-ones, REM/REMU = a.
REQ-020 SHALL treat signed overflow (a = most-negative, b = -1) as special (1-cycle): DIV = a, REM = 0.
REQ-021 SHALL hold alu_out and zero stable while out_valid && !out_ready.
REQ-022 SHALL compute zero combinationally from the registered alu_out.

Reset
REQ-023 SHALL on rst_n low, immediately and regardless of clk: state IDLE, counter 0, alu_out 0, out_valid 0, in_ready 1, zero 1.
REQ-024 SHALL discard any in-flight operation on reset; no result appears after rst_n rises.

Configuration
REQ-025 SHALL compile M-op datapath (REQ-014, REQ-018..020, MUL/DIV states) only when ALU_MULDIV_MEXT_EN is defined.
REQ-026 SHALL, without ALU_MULDIV_MEXT_EN, treat every 1xxxx code as base-latency op yielding 0; base ops unchanged.

Verification (WIDTH=32)
REQ-027 SHALL cover ADD a=5 b=7 -> out_valid 1 edge after accept, alu_out=12, zero=0; SUB 7-7 -> 0, zero=1.
REQ-028 SHALL cover MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE after 33 edges; MUL same operands -> 0x00000001; MULH 0x80000000*0x80000000 -> 0x40000000.
REQ-029 SHALL cover DIV 7/-2 -> 0xFFFFFFFD, REM -> 0x00000001 (33 edges); DIVU 9/0 -> 0xFFFFFFFF in 1 edge; REM 0x80000000/-1 -> 0 in 1 edge.
REQ-030 SHALL cover back-pressure: out_ready low 5 cycles after DONE -> alu_out held, in_ready 0; out_ready high with in_valid ADD -> back-to-back accept, next result 1 edge later.
REQ-031 SHALL cover reset at 10th cycle of DIV -> out_valid 0, alu_out 0, in_ready 1 while rst_n low; no stale result after release.
REQ-032 SHALL cover build without ALU_MULDIV_MEXT_EN: MUL 3*4 -> alu_out 0, zero 1, 1 edge latency.
